// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a start/done handshake.
// Single-cycle ops (OR, ADD, AND, NOT, SUB, XOR, SHL) complete on the start
// edge. MUL is a WIDTH-cycle shift-add unsigned multiply; busy is high while it runs.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, op, a, b, cin request and operands, sampled only while busy=0
//   busy                multiply in progress
//   done                one-cycle completion pulse
//   result, result_hi   low word / high product word (high word is 0 for non-MUL ops)
//   carry, zero, negative, overflow  status flags of the last completed op
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic { IDLE, MUL } state_t;

  typedef enum logic [2:0] {
    OP_OR  = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_SUB = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic               last_bit;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   op_res;
  logic               op_c;
  logic               op_v;

  // Single-cycle datapath
  always_comb begin
    sum    = '0;
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (op_t'(op))
      OP_OR:  op_res = a | b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: op_res = a & b;
      OP_NOT: op_res = ~a;
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the no-borrow flag.
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: op_res = a ^ b;
      OP_SHL: begin
        op_res = {a[WIDTH-2:0], 1'b0};
        op_c   = a[WIDTH-1];
      end
      default: ;
    endcase
  end

  // The multiplicand shifts left and the multiplier shifts right each step,
  // so the current multiplier bit is always mplier[0].
  always_comb begin
    acc_nx   = acc + (mplier[0] ? mcand : '0);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    busy     = (state == MUL);
    case (state)
      IDLE: if (start && (op_t'(op) == OP_MUL)) state_nx = MUL;
      MUL:  if (last_bit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (op_t'(op) == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            result    <= op_res;
            result_hi <= '0;
            carry     <= op_c;
            overflow  <= op_v;
            zero      <= (op_res == '0);
            negative  <= op_res[WIDTH-1];
            done      <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          cnt       <= '0;
          result    <= acc_nx[WIDTH-1:0];
          result_hi <= acc_nx[2*WIDTH-1:WIDTH];
          carry     <= |acc_nx[2*WIDTH-1:WIDTH];
          zero      <= (acc_nx == '0);
          negative  <= acc_nx[2*WIDTH-1];
          overflow  <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): an arithmetic reference model runs alongside
// the DUT and is compared on every falling edge; directed scenarios also
// check hand-computed literal values.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry, zero, negative, overflow;
  logic [W-1:0] result, result_hi;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carry(carry), .zero(zero), .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] h;
    logic c, z, n, v;
  } res_t;

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic res_t ref_op(input int o, input int x, input int y, input int ci);
    res_t q;
    int   r, h, s;
    r = 0; h = 0; s = 0;
    q = '0;
    case (o)
      0: r = x | y;
      1: begin r = (x + y + ci) % 256; q.c = (x + y + ci) >= 256;
               s = sgn(x) + sgn(y) + ci; q.v = (s > 127) || (s < -128); end
      2: r = x & y;
      3: r = 255 - x;
      4: begin r = (x - y + 256) % 256; q.c = (x >= y);
               s = sgn(x) - sgn(y); q.v = (s > 127) || (s < -128); end
      5: r = x ^ y;
      6: begin r = (x * 2) % 256; q.c = (x >= 128); end
      default: begin r = (x * y) % 256; h = (x * y) / 256; q.c = (h != 0); end
    endcase
    q.r = r[7:0];
    q.h = h[7:0];
    q.z = (r == 0) && (h == 0);
    q.n = (o == 7) ? (h >= 128) : (r >= 128);
    return q;
  endfunction

  // Reference model: a countdown stands in for the multiply in flight.
  int   rem;
  int   pa, pb;
  res_t m;
  logic m_done;

  always @(posedge clk) begin
    if (reset) begin
      rem <= 0; m <= '0; m_done <= 1'b0;
    end else if (rem > 1) begin
      rem <= rem - 1; m_done <= 1'b0;
    end else if (rem == 1) begin
      rem <= 0; m <= ref_op(7, pa, pb, 0); m_done <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (start === 1'b1) begin
        if (op == 3'd7) begin
          rem <= W; pa <= int'(a); pb <= int'(b);
        end else begin
          m <= ref_op(int'(op), int'(a), int'(b), int'(cin)); m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("m_busy",      32'(busy),      32'(rem != 0));
      chk("m_done",      32'(done),      32'(m_done));
      chk("m_result",    32'(result),    32'(m.r));
      chk("m_result_hi", 32'(result_hi), 32'(m.h));
      chk("m_carry",     32'(carry),     32'(m.c));
      chk("m_zero",      32'(zero),      32'(m.z));
      chk("m_negative",  32'(negative),  32'(m.n));
      chk("m_overflow",  32'(overflow),  32'(m.v));
    end
  end

  task automatic chk_lit(input string tag, input logic [7:0] r, input logic [7:0] h,
                         input logic c, input logic z, input logic n, input logic v);
    chk({tag, "_done"},  32'(done),      32'd1);
    chk({tag, "_res"},   32'(result),    32'(r));
    chk({tag, "_hi"},    32'(result_hi), 32'(h));
    chk({tag, "_carry"}, 32'(carry),     32'(c));
    chk({tag, "_zero"},  32'(zero),      32'(z));
    chk({tag, "_neg"},   32'(negative),  32'(n));
    chk({tag, "_ovf"},   32'(overflow),  32'(v));
  endtask

  // Drives start for one cycle; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic ci);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; cin = ci;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [2:0] lop [5] = '{3'd0, 3'd2, 3'd5, 3'd3, 3'd6};
  logic [7:0] lres[5] = '{8'hAF, 8'h05, 8'hAA, 8'h5A, 8'h4A};
  logic       lcar[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       lneg[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] edgev[4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    @(posedge clk); #1;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({result, result_hi, carry, zero, negative, overflow}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(3'd1, 8'hFF, 8'h01, 1'b0);
    @(negedge clk); chk_lit("add_ff_01", 8'h00, 8'h00, 1, 1, 0, 0);
    @(negedge clk); chk("add_done_pulse", 32'(done), 32'd0);

    issue(3'd4, 8'h80, 8'h01, 1'b0);
    @(negedge clk); chk_lit("sub_80_01", 8'h7F, 8'h00, 1, 0, 0, 1);
    issue(3'd4, 8'h01, 8'h02, 1'b0);
    @(negedge clk); chk_lit("sub_01_02", 8'hFF, 8'h00, 0, 0, 1, 0);

    for (int i = 0; i < 5; i++) begin
      issue(lop[i], 8'hA5, 8'h0F, 1'b0);
      @(negedge clk); chk_lit($sformatf("logic_op%0d", lop[i]), lres[i], 8'h00, lcar[i], 0, lneg[i], 0);
    end

    // MUL FF*FF with an ADD start issued mid-multiply
    issue(3'd7, 8'hFF, 8'hFF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_nodone", 32'(done), 32'd0);
      if (k == 3) begin start = 1'b1; op = 3'd1; a = 8'h01; b = 8'h01; end
      if (k == 4) start = 1'b0;
    end
    @(negedge clk);
    chk("mul_busy_fall", 32'(busy), 32'd0);
    chk_lit("mul_ff_ff", 8'h01, 8'hFE, 1, 0, 1, 0);

    // MUL 0*0x37, then ADD started in the done cycle
    issue(3'd7, 8'h00, 8'h37, 1'b0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk_lit("mul_00_37", 8'h00, 8'h00, 0, 1, 0, 0);
    start = 1'b1; op = 3'd1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk_lit("add_after_mul", 8'h07, 8'h00, 0, 0, 0, 0);

    // Reset aborts a multiply
    issue(3'd7, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_outs", 32'({result, result_hi, carry, zero, negative, overflow}), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      a     = ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 3)] : 8'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? edgev[$urandom_range(0, 3)] : 8'($urandom);
      cin   = 1'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
